// File: rtl/dregister_pipe.sv
// rtl/dregister_pipe.sv - elastic pipeline register with per-stage valid, backpressure, flush and occupancy count
//
// Purpose:
//   DEPTH chained register stages, each with its own valid bit. Data moves under a
//   valid/ready handshake. Empty stages keep accepting while the consumer stalls
//   (bubble collapsing), so a stalled pipe fills to DEPTH words.
//
// Ports:
//   i_clk    in   1      clock, rising edge
//   i_rst    in   1      asynchronous active-high reset
//   i_flush  in   1      synchronous flush, discards all stored data
//   i_valid  in   1      upstream data valid
//   o_ready  out  1      pipeline accepts i_data this cycle
//   i_data   in   WIDTH  upstream data
//   o_valid  out  1      last stage holds valid data
//   i_ready  in   1      downstream accepts o_data this cycle
//   o_data   out  WIDTH  data of the last stage
//   o_count  out  CW     number of valid stages, 0..DEPTH

module dregister_pipe #(
   parameter int               WIDTH       = 8,
   parameter int               DEPTH       = 2,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
   parameter int               CW          = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_flush,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count
);

   logic [DEPTH-1:0] v;
   logic [WIDTH-1:0] d [DEPTH];
   logic [DEPTH-1:0] rin;
   logic [DEPTH-1:0] src_v;
   logic [WIDTH-1:0] src_d [DEPTH];
   logic [CW-1:0]    count;
   logic             in_xfer;
   logic             out_xfer;

   // A stage can load when it is empty or everything downstream of it moves.
   // Unrolled from the output side: stage k is blocked only when stages
   // k..DEPTH-1 are all full and the consumer stalls. Using a scalar
   // accumulator keeps the ready chain free of self-referencing vector bits.
   always_comb begin
      logic all_full;
      all_full = 1'b1;
      rin      = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         all_full = all_full & v[k];
         rin[k]   = ~all_full | i_ready;
      end
   end

   // Source of each stage: upstream port for stage 0, previous stage otherwise.
   always_comb begin
      src_v[0] = i_valid;
      src_d[0] = i_data;
      for (int k = 1; k < DEPTH; k++) begin
         src_v[k] = v[k-1];
         src_d[k] = d[k-1];
      end
   end

   assign o_ready  = rin[0] & ~i_flush;
   assign o_valid  = v[DEPTH-1] & ~i_flush;
   assign o_data   = d[DEPTH-1];
   assign o_count  = count;

   assign in_xfer  = i_valid & o_ready;
   assign out_xfer = o_valid & i_ready;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v     <= '0;
         count <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d[k] <= RESET_VALUE;
         end
      end else if (i_flush) begin
         v     <= '0;
         count <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d[k] <= RESET_VALUE;
         end
      end else begin
         for (int k = 0; k < DEPTH; k++) begin
            if (rin[k]) begin
               v[k] <= src_v[k];
               // Data only follows a valid word, so an emptied last stage
               // keeps showing the most recent output value.
               if (src_v[k]) begin
                  d[k] <= src_d[k];
               end
            end
         end
         if (in_xfer && !out_xfer) begin
            count <= count + CW'(1);
         end else if (out_xfer && !in_xfer) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_dregister_pipe.sv
// tb/tb_dregister_pipe.sv - self-checking bench for dregister_pipe (WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5)

module tb_dregister_pipe;

   localparam int         W  = 8;
   localparam int         D  = 3;
   localparam logic [7:0] RV = 8'hA5;

   logic         clk;
   logic         rst;
   logic         flush;
   logic         valid_in;
   logic         ready_out;
   logic [W-1:0] data_in;
   logic         valid_out;
   logic         ready_in;
   logic [W-1:0] data_out;
   logic [1:0]   count;

   dregister_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VALUE(RV)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .i_flush(flush),
      .i_valid(valid_in),
      .o_ready(ready_out),
      .i_data (data_in),
      .o_valid(valid_out),
      .i_ready(ready_in),
      .o_data (data_out),
      .o_count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference model: an ordered list of in-flight words with their stage index.
   // A word advances when the slot ahead of it will be free after this edge; the
   // oldest word leaves when it sits at the end and the consumer is ready.
   typedef struct {
      logic [7:0] data;
      int         pos;
   } ent_t;

   ent_t       q[$];
   logic [7:0] m_last;
   bit         mv [D];
   logic       m_ready;
   logic       m_valid;

   task automatic model_clear();
      q.delete();
      m_last = RV;
   endtask

   task automatic model_comb(input logic fl, input logic rd);
      bit slot0_free;
      for (int i = 0; i < q.size(); i++) begin
         if (i == 0) mv[i] = (q[0].pos < D - 1) || rd;
         else        mv[i] = (q[i-1].pos != q[i].pos + 1) || mv[i-1];
      end
      slot0_free = (q.size() == 0) || (q[q.size()-1].pos != 0) || mv[q.size()-1];
      m_ready    = slot0_free && !fl;
      m_valid    = (q.size() > 0) && (q[0].pos == D - 1) && !fl;
   endtask

   task automatic model_edge(input logic fl, input logic v, input logic [7:0] dt);
      ent_t nq[$];
      ent_t e;
      if (fl) begin
         model_clear();
         return;
      end
      for (int i = 0; i < q.size(); i++) begin
         e = q[i];
         if (mv[i]) begin
            if (e.pos == D - 1) continue;
            e.pos++;
            if (e.pos == D - 1) m_last = e.data;
         end
         nq.push_back(e);
      end
      if (v && m_ready) begin
         e.data = dt;
         e.pos  = 0;
         if (D == 1) m_last = dt;
         nq.push_back(e);
      end
      q = nq;
   endtask

   // Drive one cycle's inputs at the falling edge and compare outputs with the model.
   task automatic drive(input logic fl, input logic v, input logic [7:0] dt, input logic rd);
      @(negedge clk);
      flush = fl; valid_in = v; data_in = dt; ready_in = rd;
      #1;
      model_comb(fl, rd);
      chk("model_ready", {31'd0, ready_out}, {31'd0, m_ready});
      chk("model_valid", {31'd0, valid_out}, {31'd0, m_valid});
      chk("model_data",  {24'd0, data_out},  {24'd0, m_last});
      chk("model_count", {30'd0, count},     q.size());
   endtask

   task automatic clock_edge();
      @(posedge clk);
      model_edge(flush, valid_in, data_in);
   endtask

   typedef struct {
      logic       fl;
      logic       v;
      logic [7:0] dt;
      logic       rd;
      logic       e_ready;
      logic       e_valid;
      logic [7:0] e_data;
      logic [1:0] e_count;
   } vec_t;

   vec_t tab[$];

   task automatic add(input logic fl, v, input logic [7:0] dt, input logic rd,
                      input logic er, ev, input logic [7:0] ed, input logic [1:0] ec);
      vec_t t;
      t.fl = fl; t.v = v; t.dt = dt; t.rd = rd;
      t.e_ready = er; t.e_valid = ev; t.e_data = ed; t.e_count = ec;
      tab.push_back(t);
   endtask

   int sent;
   int outs;

   initial begin
      // stall fill, then drain
      add(0,1,8'h11,0, 1,0,8'hA5,0);
      add(0,1,8'h22,0, 1,0,8'hA5,1);
      add(0,1,8'h33,0, 1,0,8'hA5,2);
      add(0,1,8'h44,0, 0,1,8'h11,3);
      add(0,1,8'h44,0, 0,1,8'h11,3);
      add(0,1,8'h44,1, 1,1,8'h11,3);
      add(0,0,8'h00,1, 1,1,8'h22,3);
      add(0,0,8'h00,1, 1,1,8'h33,2);
      add(0,0,8'h00,1, 1,1,8'h44,1);
      add(0,0,8'h00,1, 1,0,8'h44,0);
      // bubbles
      add(0,1,8'hB0,1, 1,0,8'h44,0);
      add(0,0,8'h00,1, 1,0,8'h44,1);
      add(0,1,8'hB1,1, 1,0,8'h44,1);
      add(0,0,8'h00,1, 1,1,8'hB0,2);
      add(0,0,8'h00,1, 1,0,8'hB0,1);
      add(0,0,8'h00,1, 1,1,8'hB1,1);
      add(0,0,8'h00,1, 1,0,8'hB1,0);
      // fill three words, then flush with valid and ready both high
      add(0,1,8'hC1,0, 1,0,8'hB1,0);
      add(0,1,8'hC2,0, 1,0,8'hB1,1);
      add(0,1,8'hC3,0, 1,0,8'hB1,2);
      add(1,1,8'hD0,1, 0,0,8'hC1,3);
      add(0,0,8'h00,0, 1,0,8'hA5,0);
      add(0,0,8'h00,1, 1,0,8'hA5,0);
      add(0,0,8'h00,1, 1,0,8'hA5,0);

      rst = 1'b0; flush = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
      model_clear();
      #1 rst = 1'b1;
      #1;
      chk("reset_data",  {24'd0, data_out},  32'hA5);
      chk("reset_valid", {31'd0, valid_out}, 32'd0);
      chk("reset_count", {30'd0, count},     32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_ready", {31'd0, ready_out}, 32'd1);

      for (int i = 0; i < tab.size(); i++) begin
         drive(tab[i].fl, tab[i].v, tab[i].dt, tab[i].rd);
         chk($sformatf("tab%0d_ready", i), {31'd0, ready_out}, {31'd0, tab[i].e_ready});
         chk($sformatf("tab%0d_valid", i), {31'd0, valid_out}, {31'd0, tab[i].e_valid});
         chk($sformatf("tab%0d_data",  i), {24'd0, data_out},  {24'd0, tab[i].e_data});
         chk($sformatf("tab%0d_count", i), {30'd0, count},     {30'd0, tab[i].e_count});
         clock_edge();
      end

      // streaming 01..10 back-to-back with the consumer always ready
      for (int c = 0; c < 21; c++) begin
         drive(0, c < 16, 8'(c + 1), 1);
         sent = (c < 16) ? c : 16;
         outs = (c < 3) ? 0 : ((c - 3 > 16) ? 16 : c - 3);
         chk("stream_valid", {31'd0, valid_out}, (c >= 3 && c < 19) ? 32'd1 : 32'd0);
         if (c >= 3 && c < 19) chk("stream_data", {24'd0, data_out}, c - 2);
         chk("stream_count", {30'd0, count}, sent - outs);
         clock_edge();
      end

      // asynchronous reset while two words are stored
      drive(0, 1, 8'h61, 0); clock_edge();
      drive(0, 1, 8'h62, 0); clock_edge();
      drive(0, 0, 8'h00, 0);
      chk("pre_rst_count", {30'd0, count}, 32'd2);
      rst = 1'b1;
      #1;
      model_clear();
      chk("async_rst_count", {30'd0, count},     32'd0);
      chk("async_rst_valid", {31'd0, valid_out}, 32'd0);
      chk("async_rst_data",  {24'd0, data_out},  32'hA5);
      #1 rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drive(0, c == 0, 8'h5A, 1);
         chk("post_rst_valid", {31'd0, valid_out}, (c == 3) ? 32'd1 : 32'd0);
         if (c == 3) chk("post_rst_data", {24'd0, data_out}, 32'h5A);
         clock_edge();
      end

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1), 8'($urandom), ($urandom_range(0, 2) != 0));
         clock_edge();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
